// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one synchronous single-port RAM between the CPU control block and the
// program loader. Each access walks IDLE -> ACCESS -> WAIT -> RESP, so the RAM
// sees one command every four cycles and the winner gets a one-cycle ack with
// the read data already registered on rdata.
//
// Ports
//   clk, resetn          : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata: CPU access request (held until cpu_ack)
//   ldr_req/we/addr/wdata: loader access request (held until ldr_ack)
//   loader_mode          : when high only the loader may be granted
//   cpu_ack, ldr_ack     : one-cycle completion pulses
//   rdata                : registered read data shared by both requesters
//   busy                 : high whenever an access is in flight
//   ram_en/we/addr/wdata : RAM command, valid in the ACCESS cycle
//   ram_rdata            : RAM read data, one cycle after a read command
`timescale 1ns/1ps

module ram_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              loader_mode,
  output logic              cpu_ack,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              win_cpu_q, win_cpu_d;
  logic              last_cpu_q, last_cpu_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic cpu_elig;
  logic ldr_elig;
  logic grant_cpu;

  // Next-state logic. The winner's command is copied into local registers
  // when leaving IDLE so requesters changing their inputs afterwards cannot
  // disturb the access. On a tie, whoever did not win last time goes first.
  always_comb begin
    state_d    = state_q;
    win_cpu_d  = win_cpu_q;
    last_cpu_d = last_cpu_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    cpu_elig  = cpu_req & ~loader_mode;
    ldr_elig  = ldr_req;
    grant_cpu = cpu_elig & (~ldr_elig | ~last_cpu_q);

    case (state_q)
      IDLE: begin
        if (cpu_elig | ldr_elig) begin
          state_d    = ACCESS;
          win_cpu_d  = grant_cpu;
          last_cpu_d = grant_cpu;
          we_d       = grant_cpu ? cpu_we    : ldr_we;
          addr_d     = grant_cpu ? cpu_addr  : ldr_addr;
          wdata_d    = grant_cpu ? cpu_wdata : ldr_wdata;
        end
      end
      ACCESS: state_d = WAIT;
      WAIT: begin
        // RAM output is valid now, one cycle after the read command.
        if (!we_q) begin
          rdata_d = ram_rdata;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset drops any in-flight access; the last winner
  // resets to the loader so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      win_cpu_q  <= 1'b0;
      last_cpu_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      win_cpu_q  <= win_cpu_d;
      last_cpu_q <= last_cpu_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ram_en    = (state_q == ACCESS);
  assign ram_we    = (state_q == ACCESS) & we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign cpu_ack   = (state_q == RESP) &  win_cpu_q;
  assign ldr_ack   = (state_q == RESP) & ~win_cpu_q;
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Self-checking bench for ram_port_arbiter. A behavioural RAM sits on the RAM
// port. A transaction-level reference model (arbitration by the round-robin
// rule, fixed latencies counted from the grant, and a shadow memory) predicts
// every output, and a compare process checks the DUT against it each cycle.
// Directed scenarios add hand-computed literal expectations, followed by a
// randomized phase with random requests, loader_mode toggles and resets.
`timescale 1ns/1ps

module tb_ram_port_arbiter;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int EN_LAT  = 1;
  localparam int ACK_LAT = 3;
  localparam int PERIOD  = 4;

  logic              clk;
  logic              resetn;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              ldr_req, ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              loader_mode;
  logic              cpu_ack, ldr_ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int checks_total  = 0;
  int checks_passed = 0;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .loader_mode(loader_mode),
    .cpu_ack    (cpu_ack),
    .ldr_ack    (ldr_ack),
    .rdata      (rdata),
    .busy       (busy),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous RAM with one cycle of read latency.
  bit [DATA_W-1:0] env_mem [16];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) env_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= env_mem[ram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: at most one access in flight, tracked as cycles since
  // its grant. The RAM command is expected EN_LAT cycles after the grant edge,
  // the ack ACK_LAT cycles after it, and the port is free again after PERIOD.
  bit              m_known    = 0;
  int              m_age      = 0;
  bit              m_win_cpu  = 0;
  bit              m_last_cpu = 0;
  bit              m_we       = 0;
  bit              m_rst_zero = 0;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic [DATA_W-1:0] m_read_val;
  bit [DATA_W-1:0]   model_mem [16];

  always @(posedge clk) begin : model
    bit c_el, l_el, pick;
    if (!resetn) begin
      m_known    <= 1;
      m_age      <= 0;
      m_last_cpu <= 0;
      m_rdata    <= '0;
      m_rst_zero <= 1;
    end else if (m_known) begin
      if (m_age == 0) begin
        c_el = cpu_req && !loader_mode;
        l_el = ldr_req;
        if (c_el || l_el) begin
          pick = c_el && (!l_el || !m_last_cpu);
          m_age      <= 1;
          m_win_cpu  <= pick;
          m_last_cpu <= pick;
          m_rst_zero <= 0;
          m_we       <= pick ? cpu_we    : ldr_we;
          m_addr     <= pick ? cpu_addr  : ldr_addr;
          m_wdata    <= pick ? cpu_wdata : ldr_wdata;
          if (pick ? cpu_we : ldr_we)
            model_mem[pick ? cpu_addr : ldr_addr] <= pick ? cpu_wdata : ldr_wdata;
          else
            m_read_val <= model_mem[pick ? cpu_addr : ldr_addr];
        end
      end else begin
        if (m_age + 1 == ACK_LAT && !m_we) m_rdata <= m_read_val;
        m_age <= (m_age + 1 == PERIOD) ? 0 : m_age + 1;
      end
    end
  end

  // Compare process: every cycle after the first reset.
  always @(negedge clk) begin
    if (m_known) begin
      checkOutput("busy",    32'(busy),    32'(m_age != 0));
      checkOutput("ram_en",  32'(ram_en),  32'(m_age == EN_LAT));
      checkOutput("ram_we",  32'(ram_we),  32'(m_age == EN_LAT && m_we));
      checkOutput("cpu_ack", 32'(cpu_ack), 32'(m_age == ACK_LAT && m_win_cpu));
      checkOutput("ldr_ack", 32'(ldr_ack), 32'(m_age == ACK_LAT && !m_win_cpu));
      checkOutput("rdata",   32'(rdata),   32'(m_rdata));
      if (m_age == EN_LAT) begin
        checkOutput("ram_addr",  32'(ram_addr),  32'(m_addr));
        checkOutput("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
      end
      if (m_rst_zero) begin
        checkOutput("ram_addr_rst",  32'(ram_addr),  32'(0));
        checkOutput("ram_wdata_rst", 32'(ram_wdata), 32'(0));
      end
    end
  end

  function automatic logic [DATA_W-1:0] pat(input int i);
    if (i == 3) return 8'hA5;
    return 8'(i * 19 + 7);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One randomized cycle: requesters follow the hold-until-ack protocol.
  task automatic applyStimulus();
    logic c_ack, l_ack;
    @(negedge clk);
    c_ack = cpu_ack;
    l_ack = ldr_ack;
    tick();
    resetn = ($urandom_range(0, 59) != 0);
    if ($urandom_range(0, 7) == 0) loader_mode = ~loader_mode;
    if (c_ack) cpu_req = 1'b0;
    else if (!cpu_req && $urandom_range(0, 2) == 0) begin
      cpu_req   = 1'b1;
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 4'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom);
    end
    if (l_ack) ldr_req = 1'b0;
    else if (!ldr_req && $urandom_range(0, 2) == 0) begin
      ldr_req   = 1'b1;
      ldr_we    = 1'($urandom_range(0, 1));
      ldr_addr  = 4'($urandom_range(0, 15));
      ldr_wdata = 8'($urandom);
    end
  endtask

  // Single access by one requester; returns cycles to ack and data at ack.
  task automatic doAccess(input bit is_cpu, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, output int lat, output logic [DATA_W-1:0] rd);
    bit done = 0;
    lat = 0;
    rd  = '0;
    if (is_cpu) begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
    else        begin ldr_req = 1; ldr_we = we; ldr_addr = addr; ldr_wdata = wd; end
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if ((is_cpu && cpu_ack) || (!is_cpu && ldr_ack)) begin
        done = 1;
        rd   = rdata;
      end
      tick();
    end
    if (is_cpu) cpu_req = 0; else ldr_req = 0;
    if (!done) checkOutput("ack_timeout", 32'(0), 32'(1));
  endtask

  // Runs until both pending requests are acked; reports ack cycle of each.
  task automatic runPair(output int c_lat, output int l_lat);
    int k = 0;
    logic c, l;
    c_lat = 0;
    l_lat = 0;
    while ((cpu_req || ldr_req) && k < 30) begin
      @(negedge clk);
      k++;
      c = cpu_ack;
      l = ldr_ack;
      if (c) c_lat = k;
      if (l) l_lat = k;
      tick();
      if (c) cpu_req = 0;
      if (l) ldr_req = 0;
    end
    if (cpu_req || ldr_req) checkOutput("pair_timeout", 32'(0), 32'(1));
    cpu_req = 0;
    ldr_req = 0;
  endtask

  initial begin : stim
    int lat, c_lat, l_lat, c_cnt, l_cnt;
    logic [DATA_W-1:0] rd;

    // Reset with random inputs for two cycles.
    resetn = 0;
    for (int i = 0; i < 2; i++) begin
      cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 4'($urandom); cpu_wdata = 8'($urandom);
      ldr_req = 1'($urandom); ldr_we = 1'($urandom); ldr_addr = 4'($urandom); ldr_wdata = 8'($urandom);
      loader_mode = 1'($urandom);
      tick();
    end
    resetn = 1; cpu_req = 0; ldr_req = 0; loader_mode = 0;
    @(negedge clk);
    checkOutput("rst_busy",    32'(busy),     32'(0));
    checkOutput("rst_ram_en",  32'(ram_en),   32'(0));
    checkOutput("rst_acks",    32'({cpu_ack, ldr_ack}), 32'(0));
    checkOutput("rst_rdata",   32'(rdata),    32'(0));
    checkOutput("rst_ramaddr", 32'(ram_addr), 32'(0));
    tick();

    // Loader fills the RAM while only it is eligible.
    loader_mode = 1;
    for (int i = 0; i < 16; i++) begin
      doAccess(0, 1, 4'(i), pat(i), lat, rd);
      checkOutput("load_lat", 32'(lat), 32'(4));
    end
    loader_mode = 0;

    // CPU read of address 3: command at N+1, ack and data at N+3.
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd3; cpu_wdata = 8'h00;
    @(negedge clk); tick();
    @(negedge clk);
    checkOutput("rd_ram_en",   32'(ram_en),   32'(1));
    checkOutput("rd_ram_we",   32'(ram_we),   32'(0));
    checkOutput("rd_ram_addr", 32'(ram_addr), 32'(3));
    tick(); @(negedge clk); tick();
    @(negedge clk);
    checkOutput("rd_cpu_ack", 32'(cpu_ack), 32'(1));
    checkOutput("rd_rdata",   32'(rdata),   32'(8'hA5));
    tick(); cpu_req = 0;

    // Tie straight after reset: cpu first, ldr four cycles later, twice.
    resetn = 0; tick(); resetn = 1;
    for (int r = 0; r < 2; r++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 4'd3;
      ldr_req = 1; ldr_we = 0; ldr_addr = 4'd5;
      runPair(c_lat, l_lat);
      checkOutput("tie_cpu_lat", 32'(c_lat), 32'(4));
      checkOutput("tie_ldr_lat", 32'(l_lat), 32'(8));
    end

    // loader_mode holds the CPU off while the loader keeps requesting.
    loader_mode = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd5;
    ldr_req = 1; ldr_we = 0; ldr_addr = 4'd3;
    c_cnt = 0; l_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      c_cnt += int'(cpu_ack);
      l_cnt += int'(ldr_ack);
      tick();
    end
    loader_mode = 0; ldr_req = 0;
    checkOutput("lm_cpu_acks", 32'(c_cnt), 32'(0));
    checkOutput("lm_ldr_acks", 32'(l_cnt), 32'(3));
    runPair(c_lat, l_lat);
    checkOutput("lm_cpu_lat", 32'(c_lat), 32'(4));

    // Write then read back through different requesters.
    doAccess(1, 0, 4'd3, 8'h00, lat, rd);
    checkOutput("wr_pre_rdata", 32'(rd), 32'(8'hA5));
    doAccess(0, 1, 4'hF, 8'h3C, lat, rd);
    checkOutput("wr_rdata_kept", 32'(rd), 32'(8'hA5));
    checkOutput("wr_lat", 32'(lat), 32'(4));
    doAccess(1, 0, 4'hF, 8'h00, lat, rd);
    checkOutput("rb_rdata", 32'(rd), 32'(8'h3C));
    checkOutput("rb_lat",   32'(lat), 32'(4));

    // Reset during WAIT drops the access; the held request is served again.
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd3;
    @(negedge clk); tick();
    @(negedge clk);
    checkOutput("mr_ram_en", 32'(ram_en), 32'(1));
    tick(); resetn = 0;
    @(negedge clk);
    checkOutput("mr_wait_ack", 32'(cpu_ack), 32'(0));
    tick(); resetn = 1;
    @(negedge clk);
    checkOutput("mr_busy",  32'(busy),   32'(0));
    checkOutput("mr_acks",  32'({cpu_ack, ldr_ack}), 32'(0));
    checkOutput("mr_rdata", 32'(rdata),  32'(0));
    checkOutput("mr_ramen", 32'({ram_en, ram_we}), 32'(0));
    tick(); @(negedge clk); tick(); @(negedge clk); tick();
    @(negedge clk);
    checkOutput("mr_cpu_ack", 32'(cpu_ack), 32'(1));
    checkOutput("mr_rdata2",  32'(rdata),   32'(8'hA5));
    tick(); cpu_req = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) applyStimulus();
    resetn = 1; cpu_req = 0; ldr_req = 0; loader_mode = 0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, giving the RAM address width (16-word program/data RAM).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the RAM and bus data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have ports cpu_req (input, 1), cpu_we (input, 1), cpu_addr (input, ADDR_W) and cpu_wdata (input, DATA_W): the CPU-side access request, driven by the control block's RAM/MAR strobes.
REQ-006 The block SHALL have ports ldr_req (input, 1), ldr_we (input, 1), ldr_addr (input, ADDR_W) and ldr_wdata (input, DATA_W): the program-loader access request.
REQ-007 The block SHALL have port loader_mode, input, 1 bit: when high, only the loader is eligible for grant.
REQ-008 The block SHALL have ports cpu_ack and ldr_ack, output, 1 bit each: one-cycle completion pulses.
REQ-009 The block SHALL have port rdata, output, DATA_W: the registered read data, shared by both requesters.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have ports ram_en (output, 1), ram_we (output, 1), ram_addr (output, ADDR_W) and ram_wdata (output, DATA_W): the synchronous single-port RAM command; RAM read latency is 1 cycle.
REQ-012 The block SHALL have port ram_rdata, input, DATA_W: RAM read data, valid the cycle after ram_en with ram_we low.

Function
REQ-013 The FSM SHALL have states IDLE, ACCESS, WAIT and RESP, with transitions IDLE->ACCESS on an eligible request, ACCESS->WAIT, WAIT->RESP and RESP->IDLE, all unconditional except the first.
REQ-014 In IDLE, eligible requesters SHALL be: cpu if cpu_req=1 and loader_mode=0; ldr if ldr_req=1.
REQ-015 When both requesters are eligible, the requester not granted most recently SHALL win; the last-winner register resets to ldr, so cpu wins the first tie.
REQ-016 On the IDLE->ACCESS edge, the arbiter SHALL latch the winner's we, addr and wdata, together with the winner id; later changes on the request inputs do not affect the in-flight access.
REQ-017 In ACCESS, ram_en SHALL be 1, and ram_we, ram_addr and ram_wdata SHALL equal the latched values; in all other states ram_en=0 and ram_we=0.
REQ-018 In WAIT, a read SHALL capture ram_rdata into rdata; a write SHALL leave rdata unchanged.
REQ-019 In RESP, exactly one of cpu_ack or ldr_ack SHALL be 1, matching the latched winner; rdata SHALL be stable.
REQ-020 Latency: with a request sampled at the IDLE edge ending cycle N, ram_en SHALL be high in N+1 and ack high in N+3; throughput is one access per 4 cycles.
REQ-021 A requester SHALL hold req and its command stable until its ack, and SHALL drop req on the edge ending the ack cycle; a req still high in the following IDLE cycle is a new request.
REQ-022 loader_mode SHALL be sampled only in IDLE; toggling it mid-transaction does not abort or reassign the access.
REQ-023 A request that is not eligible or not granted SHALL wait without a timeout and without an ack.

Reset
REQ-024 While resetn=0 at a clock edge, the state SHALL become IDLE, and cpu_ack, ldr_ack, ram_en, ram_we and busy SHALL be 0.
REQ-025 While resetn=0 at a clock edge, ram_addr, ram_wdata and rdata SHALL become 0, and the last winner SHALL become ldr.
REQ-026 A reset in ACCESS, WAIT or RESP SHALL drop the in-flight access with no ack, including any pending ack.
REQ-027 The first access after a mid-operation reset SHALL be served normally.

Verification
REQ-028 Scenario reset: resetn=0 for 2 cycles with random inputs -> all outputs 0 and busy=0.
REQ-029 Scenario read: RAM[3]=8'hA5, cpu_req with we=0 and addr=3 -> ram_en=1, we=0, addr=3 at N+1; cpu_ack=1 and rdata=8'hA5 at N+3.
REQ-030 Scenario tie: both requesters assert req in the same cycle after reset -> cpu acked first, then ldr acked 4 cycles later; a repeat tie grants cpu after ldr.
REQ-031 Scenario loader_mode: loader_mode=1 with both requesting continuously -> only ldr_ack pulses; cpu is acked within 4 cycles of the next IDLE after loader_mode=0.
REQ-032 Scenario write-then-read: ldr writes addr F with data 8'h3C, then cpu reads addr F -> rdata unchanged during the write, and rdata=8'h3C at the cpu_ack.
REQ-033 Scenario reset mid-access: resetn=0 for 1 cycle during WAIT -> no ack, all outputs 0; the next cpu read completes with the correct data at N+3.
